// File: rtl/midi_pkg.sv
// Shared types and helpers for the MIDI message scheduler.
//   midi_len_e   : decoded message length (1, 2 or 3 bytes) or LEN_BAD for rejected status bytes
//   midi_msg_t   : one buffered message (status, two data bytes, length code)
//   midi_msg_len : status byte -> length code
//   midi_len_bytes : length code -> byte count (0 for LEN_BAD)
package midi_pkg;

  localparam int unsigned MIDI_BITS_PER_BYTE = 10;  // start + 8 data + stop

  typedef enum logic [1:0] {
    LEN_1   = 2'd0,
    LEN_2   = 2'd1,
    LEN_3   = 2'd2,
    LEN_BAD = 2'd3
  } midi_len_e;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    midi_len_e  len;
  } midi_msg_t;

  function automatic midi_len_e midi_msg_len(input logic [7:0] st);
    midi_len_e len;
    casez (st)
      8'b10??_????, 8'b1110_????, 8'hF2: len = LEN_3;  // 0x80-0xBF, 0xE0-0xEF, song position
      8'b110?_????, 8'hF1, 8'hF3:        len = LEN_2;  // 0xC0-0xDF, MTC quarter frame, song select
      8'hF6, 8'b1111_1???:               len = LEN_1;  // tune request, real-time 0xF8-0xFF
      default:                           len = LEN_BAD;  // data bytes, SysEx, undefined 0xF4/5
    endcase
    return len;
  endfunction

  function automatic int unsigned midi_len_bytes(input midi_len_e len);
    int unsigned n;
    unique case (len)
      LEN_1:   n = 1;
      LEN_2:   n = 2;
      LEN_3:   n = 3;
      default: n = 0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Synchronous FIFO of midi_msg_t entries with registered full/empty flags.
//   clk, rst      : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i/wdata_i: write an entry (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   rdata_o       : current head entry (valid while !empty_o)
//   full_o/empty_o: registered occupancy flags
module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  midi_msg_t wdata_i,
  input  logic      pop_i,
  output midi_msg_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;  // extra wrap bit tells full from empty

  midi_msg_t         mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d == {~rd_ptr_d[AW], rd_ptr_d[AW-1:0]});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: contents are only read while the pointers say valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/midi_msg_sched.sv
// MIDI message scheduler: buffers complete messages and issues them one at a time to the UART
// transmitter, then holds off for the serial frame time plus a guard.
//   clk, rst                    : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     : message handshake (in_ready_o = !full, registered)
//   in_status_i, in_data1_i/2_i : offered message bytes
//   status_o, data1_o, data2_o  : message to transmitter (unused data bytes forced to 0x00)
//   cmd_bits_cnt_o              : serial bits to send (10, 20 or 30)
//   cmd_set_o                   : one-cycle issue strobe
//   busy_o                      : high from issue until the frame wait expires
//   drop_cnt_o                  : saturating count of rejected messages
module midi_msg_sched
  import midi_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BIT_CYCLES = 1600,
  parameter int unsigned GUARD_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_status_i,
  input  logic [7:0] in_data1_i,
  input  logic [7:0] in_data2_i,
  output logic [7:0] status_o,
  output logic [7:0] data1_o,
  output logic [7:0] data2_o,
  output logic [7:0] cmd_bits_cnt_o,
  output logic       cmd_set_o,
  output logic       busy_o,
  output logic [7:0] drop_cnt_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  data1_q, data1_d;
  logic [7:0]  data2_q, data2_d;
  logic [7:0]  bits_q, bits_d;
  logic        cmd_set_q, cmd_set_d;
  logic        busy_q, busy_d;
  logic [7:0]  drop_q;

  midi_len_e   in_len;
  midi_msg_t   in_msg;
  midi_msg_t   head;
  logic        fifo_full, fifo_empty;
  logic        accept, push, drop, pop;
  int unsigned head_bytes;
  int unsigned frame_cycles;

  assign in_len     = midi_msg_len(in_status_i);
  assign in_ready_o = !fifo_full;
  assign accept     = in_valid_i && in_ready_o;
  assign push       = accept && (in_len != LEN_BAD);
  assign drop       = accept && (in_len == LEN_BAD);
  assign pop        = (state_q == StIssue);

  assign in_msg = '{status: in_status_i, data1: in_data1_i, data2: in_data2_i, len: in_len};

  midi_msg_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (in_msg),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_bytes   = midi_len_bytes(head.len);
  assign frame_cycles = (MIDI_BITS_PER_BYTE * head_bytes + GUARD_BITS) * BIT_CYCLES;

  // Outputs are loaded on the IDLE->ISSUE edge so that they are already valid while cmd_set is
  // high. The timer also starts counting in the ISSUE cycle, so ISSUE+WAIT spans exactly one frame.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    status_d  = status_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    bits_d    = bits_q;
    cmd_set_d = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d   = StIssue;
          status_d  = head.status;
          data1_d   = (head.len != LEN_1) ? head.data1 : 8'h00;
          data2_d   = (head.len == LEN_3) ? head.data2 : 8'h00;
          bits_d    = 8'(MIDI_BITS_PER_BYTE * head_bytes);
          timer_d   = frame_cycles - 32'd1;
          cmd_set_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
        timer_d = timer_q - 32'd1;
      end
      StWait: begin
        if (timer_q == 32'd0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      status_q  <= '0;
      data1_q   <= '0;
      data2_q   <= '0;
      bits_q    <= '0;
      cmd_set_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      status_q  <= status_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      bits_q    <= bits_d;
      cmd_set_q <= cmd_set_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign status_o       = status_q;
  assign data1_o        = data1_q;
  assign data2_o        = data2_q;
  assign cmd_bits_cnt_o = bits_q;
  assign cmd_set_o      = cmd_set_q;
  assign busy_o         = busy_q;
  assign drop_cnt_o     = drop_q;

endmodule

// File: doc/midi_msg_sched.md
Name: midi_msg_sched

Overview:
- Upstream feeder for the MIDI UART transmitter.
- Accepts complete MIDI messages over a valid/ready interface and buffers them in a small FIFO.
- Decodes the message length from the status byte and drops illegal messages.
- Presents one message at a time on the transmitter's command bus with a single-cycle cmd_set pulse. It then holds off the next issue until a clk-domain timer covers the full serial frame plus a guard.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2, minimum 2.
- BIT_CYCLES, 1600: clk cycles per MIDI bit (50 MHz / 31250).
- GUARD_BITS, 2: extra bit-times added to each frame wait; absorbs baud_clk/clk phase uncertainty.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  message offered
- in_ready  out  1  FIFO can accept; equals !full (registered)
- in_status  in  8  status byte
- in_data1  in  8  first data byte
- in_data2  in  8  second data byte
- status  out  8  to transmitter
- data1  out  8  to transmitter
- data2  out  8  to transmitter
- cmd_bits_cnt  out  8  serial bits to send: 10, 20 or 30
- cmd_set  out  1  one-clk issue strobe
- busy  out  1  high from the issue cycle until the frame wait expires
- drop_cnt  out  8  saturating count of rejected messages

Behaviour:
- Reset: all outputs 0 except in_ready=1; FIFO empty; state IDLE; timer 0; drop_cnt 0.
- Length decode (byte count = 1 status byte plus its data bytes):
  - 3 bytes: status 0x80-0xBF, 0xE0-0xEF, 0xF2.
  - 2 bytes: 0xC0-0xDF, 0xF1, 0xF3.
  - 1 byte: 0xF6, 0xF8-0xFF.
  - Invalid: bit7=0, or 0xF0, 0xF4, 0xF5, 0xF7.
- Push: on in_valid && in_ready.
  - Valid message: write status, data1, data2 and the 2-bit length code.
  - Invalid message: not written; drop_cnt += 1, saturating at 255. in_ready is unaffected.
- FIFO occupancy is tracked with DEPTH+1-state pointers. full and empty are registered. in_ready reflects the prior cycle's full, so a push is refused in a simultaneous pop-while-full cycle.
- States:
  - IDLE: if !empty, go to ISSUE.
  - ISSUE (one cycle):
    - Pop the head entry; register status, data1, data2.
    - Data bytes beyond the message length are driven as 0x00.
    - cmd_bits_cnt = 10 * bytes.
    - cmd_set=1 and busy=1 this cycle.
    - Load timer = (10*bytes + GUARD_BITS) * BIT_CYCLES - 1.
    - Go to WAIT.
  - WAIT: busy=1; decrement timer; at timer==0, go to IDLE.
- Latency:
  - Push into an empty FIFO while IDLE: cmd_set fires 2 clk later (one cycle IDLE->ISSUE, then the ISSUE cycle).
  - Back-to-back messages: next cmd_set fires exactly (10*bytes + GUARD_BITS) * BIT_CYCLES + 1 clk after the previous one.
- status, data1, data2 and cmd_bits_cnt hold their values until the next ISSUE.
- Timer width: 32 bits. Product arithmetic uses 32 bits; no overflow at default parameters.
- Asynchronous reset mid-WAIT or mid-ISSUE: FIFO is flushed and the in-flight message is abandoned (the transmitter is reset by the same rst).
- A push during ISSUE/WAIT is accepted normally if not full.

Decomposition:
- Package midi_pkg:
  - Length-code enum: LEN_1, LEN_2, LEN_3, LEN_BAD.
  - Function midi_msg_len(status) returning the enum.
  - Constant MIDI_BITS_PER_BYTE=10.
  - Packed struct midi_msg_t: status, data1, data2, len.
- One sub-module: midi_msg_fifo, a synchronous FIFO of midi_msg_t with DEPTH parameter and registered full/empty. Scheduler FSM and timer stay in the top.

Test Plan (BIT_CYCLES=4, GUARD_BITS=2, DEPTH=4):
- Single note-on: push 0x90/0x3C/0x64 -> cmd_set 2 clk later with status 0x90, data1 0x3C, data2 0x64, cmd_bits_cnt 30; busy high for 128 clk.
- Program change: push 0xC5/0x07/0xAA -> data1 0x07, data2 0x00, cmd_bits_cnt 20; busy 88 clk.
- Real-time clock: push 0xF8 -> cmd_bits_cnt 10, data1=data2=0x00; back-to-back 0xF8 pairs show cmd_set spacing of 49 clk.
- Invalid messages: push 0x40, 0xF0, 0xF7 -> no cmd_set, drop_cnt=3. After 256 invalid pushes, drop_cnt stays 255.
- Fill: push 6 valid note-ons back-to-back -> in_ready low once 4 entries are queued (first popped at ISSUE, so 5 accepted before stall); all messages issue in order; no loss or duplication.
- Reset mid-WAIT with 3 queued: assert rst -> outputs return to reset values, in_ready=1, no cmd_set after release until a new push.
